// File: rtl/cardinal_scoreboard.sv
// rtl/cardinal_scoreboard.sv - issue/writeback scoreboard with RR writeback arbiter; optional CARDINAL_SB_FWD_EN
module cardinal_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int NFU     = 4,
  parameter int FW      = 2,
  parameter int MAX_OUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_v,
  input  logic [FW-1:0]     issue_fu,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_rd_v,
  input  logic [AW-1:0]     issue_rs1,
  input  logic              issue_rs1_v,
  input  logic [AW-1:0]     issue_rs2,
  input  logic              issue_rs2_v,
  input  logic [NFU-1:0]    fu_busy,
  output logic              issue_ok,
  output logic              stall,
  output logic [NFU-1:0]    fu_start,
  output logic              fwd_a,
  output logic              fwd_b,
  input  logic [NFU-1:0]    wb_req,
  input  logic [NFU*AW-1:0] wb_rd,
  output logic [NFU-1:0]    wb_gnt,
  output logic              wb_we,
  output logic [AW-1:0]     wb_addr,
  output logic [FW-1:0]     wb_sel,
  output logic              idle,
  output logic              err
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [FW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;

  logic            gnt_found;
  logic [FW-1:0]   gnt_idx;
  logic            grant_v;
  logic [AW-1:0]   grant_rd;
  logic [NREG-1:0] pend_eff, pend_raw, set_vec;
  logic            raw_a, raw_b, waw, fu_valid, busy_sel, cap_ok;

  // One-hot register decode; r0 never maps to a pending bit.
  function automatic logic [NREG-1:0] dec(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    for (int r = 1; r < NREG; r++) begin
      if (a == AW'(r)) v[r] = 1'b1;
    end
    return v;
  endfunction

  // Round-robin search: first requester at or after rr_ptr, then wrap to the low indices.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NFU; i++) begin
      if (!gnt_found && wb_req[i] && (FW'(i) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = FW'(i);
      end
    end
    for (int i = 0; i < NFU; i++) begin
      if (!gnt_found && wb_req[i] && (FW'(i) < rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = FW'(i);
      end
    end
  end

  // Writeback port drive, hazard checks, issue decision and next-state computation.
  always_comb begin
    grant_v  = gnt_found & ~reset;
    grant_rd = '0;
    wb_gnt   = '0;
    for (int i = 0; i < NFU; i++) begin
      if (gnt_idx == FW'(i)) grant_rd = wb_rd[i*AW +: AW];
      wb_gnt[i] = grant_v && (gnt_idx == FW'(i));
    end
    wb_we   = grant_v;
    wb_addr = grant_v ? grant_rd : '0;
    wb_sel  = grant_v ? gnt_idx : '0;

    // A register retiring this cycle no longer blocks a WAW; RAW only when forwarding exists.
    pend_eff = pending_q & ~(grant_v ? dec(grant_rd) : '0);
`ifdef CARDINAL_SB_FWD_EN
    pend_raw = pend_eff;
    fwd_a = issue_v & issue_rs1_v & grant_v & (issue_rs1 != '0) & (issue_rs1 == grant_rd);
    fwd_b = issue_v & issue_rs2_v & grant_v & (issue_rs2 != '0) & (issue_rs2 == grant_rd);
`else
    pend_raw = pending_q;
    fwd_a = 1'b0;
    fwd_b = 1'b0;
`endif
    raw_a = issue_rs1_v & (|(pend_raw & dec(issue_rs1)));
    raw_b = issue_rs2_v & (|(pend_raw & dec(issue_rs2)));
    waw   = issue_rd_v & (|(pend_eff & dec(issue_rd)));

    fu_valid = ({1'b0, issue_fu} < (FW+1)'(NFU));
    busy_sel = 1'b1;
    for (int i = 0; i < NFU; i++) begin
      if (issue_fu == FW'(i)) busy_sel = fu_busy[i];
    end
    cap_ok = (out_cnt_q < CW'(MAX_OUT)) | grant_v;

    issue_ok = ~reset & issue_v & fu_valid & ~busy_sel & ~raw_a & ~raw_b & ~waw & cap_ok;
    stall    = issue_v & ~issue_ok;
    fu_start = '0;
    for (int i = 0; i < NFU; i++) begin
      fu_start[i] = issue_ok && (issue_fu == FW'(i));
    end

    // Clear-then-set ordering keeps a same-cycle retire/reissue of one register pending.
    set_vec   = (issue_ok & issue_rd_v) ? dec(issue_rd) : '0;
    pending_d = pend_eff | set_vec;

    out_cnt_d = out_cnt_q;
    if (issue_ok && !grant_v) out_cnt_d = out_cnt_q + CW'(1);
    else if (!issue_ok && grant_v && (out_cnt_q != '0)) out_cnt_d = out_cnt_q - CW'(1);

    rr_ptr_d = rr_ptr_q;
    if (grant_v) rr_ptr_d = (gnt_idx == FW'(NFU-1)) ? '0 : gnt_idx + FW'(1);

    err_d = err_q
          | (grant_v & (grant_rd != '0) & ~(|(pending_q & dec(grant_rd))))
          | (grant_v & (out_cnt_q == '0))
          | (issue_v & ~fu_valid);

    idle = reset | ((out_cnt_q == '0) & (pending_q == '0));
    err  = err_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      out_cnt_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      out_cnt_q <= out_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/cardinal_scoreboard.md
Name: cardinal_scoreboard

Overview:
- Parametrised issue/writeback scoreboard for the Cardinal core's next-generation variable-latency execute stage. It sits between decode and the functional units (FUs: add, mul, div, sqrt, ...).
- Tracks pending destination registers and stalls decode on RAW/WAW hazards and on in-flight overflow.
- Arbitrates FU results onto the single register-file write port, round-robin, and raises operand-forward selects when a source is written back in the same cycle it is needed.

Parameters:
NREG, 32, architectural register count; r0 is hardwired zero and never pending
AW, 5, register address width; NREG <= 2**AW
NFU, 4, number of functional units
FW, 2, FU index width; NFU <= 2**FW
MAX_OUT, 8, maximum in-flight instructions; counter width is clog2(MAX_OUT+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue_v  in  1  decode holds a valid ALU instruction
issue_fu  in  FW  target FU index
issue_rd  in  AW  destination register
issue_rd_v  in  1  instruction writes issue_rd
issue_rs1  in  AW  source A
issue_rs1_v  in  1  source A used
issue_rs2  in  AW  source B
issue_rs2_v  in  1  source B used
fu_busy  in  NFU  bit i: FU i cannot accept this cycle
issue_ok  out  1  instruction accepted this cycle (combinational)
stall  out  1  issue_v & ~issue_ok
fu_start  out  NFU  one-hot start pulse to FU issue_fu
fwd_a  out  1  source A equals wb_addr this cycle; take operand from wb bus
fwd_b  out  1  same for source B
wb_req  in  NFU  bit i: FU i holds a result
wb_rd  in  NFU*AW  FU i destination in field i, bits i*AW .. i*AW+AW-1 from index 0
wb_gnt  out  NFU  one-hot grant; FU i drops or advances its result on grant
wb_we  out  1  register-file write enable
wb_addr  out  AW  register-file write address
wb_sel  out  FW  index of granted FU (result mux select)
idle  out  1  in-flight count == 0 and no pending bits
err  out  1  sticky protocol error

Behaviour:
- State: pending[NREG-1:0], out_cnt, rr_ptr (FW bits), err. Reset sets all to 0. While reset is high, issue_ok, fu_start, wb_gnt and wb_we are forced to 0, and idle=1.
- Writeback arbitration (combinational):
  - Grant the first requesting FU at or after rr_ptr, with wrap-around.
  - wb_we = |wb_gnt. wb_addr = wb_rd field of the grantee. wb_sel = grantee index.
  - No request: wb_gnt=0, wb_we=0, wb_addr=0, wb_sel=0.
  - On a grant, rr_ptr <= grantee+1, wrapping at NFU to 0. With no grant, rr_ptr holds.
  - A grantee with wb_rd=0 gets wb_we=1 (the register file ignores the write), still decrements out_cnt, and clears nothing.
- Hazard check:
  - RAW when a used source != 0 and its pending bit is set.
  - WAW when issue_rd_v, issue_rd != 0 and pending[issue_rd] is set.
  - A pending register being granted this cycle counts as not pending, for both RAW (with forwarding) and WAW.
- issue_ok = issue_v & ~fu_busy[issue_fu] & ~RAW & ~WAW & (out_cnt < MAX_OUT, or a writeback this cycle). issue_fu >= NFU forces issue_ok=0 and sets err.
- fu_start[issue_fu] = issue_ok. Zero latency from issue_v; the FU samples operands on the same edge.
- Pending update per edge:
  - Clear the granted rd first.
  - Then set issue_rd if issue_ok & issue_rd_v & issue_rd != 0.
  - Same-register clear and set in one cycle leaves the bit at 1.
- out_cnt: +1 on issue_ok, -1 on grant, unchanged when both occur. Never exceeds MAX_OUT.
- err sets (sticky until reset) on:
  - a grant whose rd != 0 has pending=0;
  - a grant while out_cnt=0;
  - an invalid issue_fu.
- Reset mid-operation discards all pending state; FUs are reset by the same signal.

Optional Feature:
CARDINAL_SB_FWD_EN
- Defined: same-cycle forwarding as above. A source being written back this cycle is not a RAW hazard; fwd_a/fwd_b assert for that source.
- Undefined: fwd_a=fwd_b=0 constant, and any set pending bit is a RAW hazard even if granted this cycle. Issue waits one cycle, then reads the register file. WAW clearing is unchanged.

Test Plan:
- Reset, then issue add (fu0) rd=3, rs1=1, rs2=2 -> issue_ok=1, fu_start=0001, pending[3]=1, out_cnt=1, idle=0.
- Next cycle issue rs1=3 while fu0 has no wb_req -> stall=1. Assert wb_req=0001 with rd=3 -> wb_we=1, wb_addr=3, and:
  - FWD_EN defined: issue_ok=1, fwd_a=1.
  - FWD_EN undefined: stall that cycle, issue_ok the cycle after, fwd_a=0.
- Pending rd=5 (mul), then issue div rd=5 -> WAW stall until mul grant; same-cycle reissue leaves pending[5]=1.
- wb_req=1111 held for 4 cycles from rr_ptr=0 -> grants 0001, 0010, 0100, 1000; rr_ptr returns to 0.
- Issue 8 instructions without writeback -> 9th stalls with out_cnt=8. A grant in the same cycle -> 9th issues and out_cnt stays 8.
- Grant for rd=7 with pending[7]=0 -> err=1 and stays 1 until reset. Reset asserted mid-stream -> pending=0, out_cnt=0, idle=1, err=0.
